// File: rtl/apb_mas_arb_ctrl.sv
// Round-robin arbitrated APB master: shares one APB bus among NUM_REQ requesters,
// sequences SETUP/ACCESS, returns a one-cycle response with a PREADY timeout guard.
module apb_mas_arb_ctrl #(
  parameter int NUM_REQ         = 4,
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int APB_DATA_WIDTH  = 32,
  parameter int APB_STROB_WIDTH = APB_DATA_WIDTH/8,
  parameter int TIMEOUT         = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0]                   req_write,
  input  logic [NUM_REQ*APB_STROB_WIDTH-1:0]   req_strob,
  input  logic [NUM_REQ*3-1:0]                 req_prot,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [APB_DATA_WIDTH-1:0]            resp_rdata,
  output logic                                 resp_err,
  output logic                                 PSEL,
  output logic                                 PENABLE,
  output logic                                 PWRITE,
  output logic [APB_ADDR_WIDTH-1:0]            PADDR,
  output logic [APB_DATA_WIDTH-1:0]            PWDATA,
  output logic [APB_STROB_WIDTH-1:0]           PSTROB,
  output logic [2:0]                           PPROT,
  input  logic                                 PREADY,
  input  logic                                 PSLVERR,
  input  logic [APB_DATA_WIDTH-1:0]            PRDATA
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0]  addr;
    logic [APB_DATA_WIDTH-1:0]  wdata;
    logic                       write;
    logic [APB_STROB_WIDTH-1:0] strob;
    logic [2:0]                 prot;
  } req_t;

  req_t reqs [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign reqs[i].addr  = req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
    assign reqs[i].wdata = req_wdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    assign reqs[i].write = req_write[i];
    assign reqs[i].strob = req_strob[i*APB_STROB_WIDTH +: APB_STROB_WIDTH];
    assign reqs[i].prot  = req_prot[i*3 +: 3];
  end

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, owner, gnt_idx;
  logic [CW-1:0] wcnt;
  logic          gnt_any, gnt_en, gnt, done, tmo;

  // Abort on the last allowed wait cycle if the slave still stalls.
  assign tmo    = TMO_EN && (state == ACCESS) && !PREADY && (wcnt == CNT_LAST);
  assign done   = (state == ACCESS) && (PREADY || tmo);
  assign gnt_en = (state == IDLE) || done;
  assign gnt    = gnt_en && gnt_any;

  // Rotating priority: first valid requester at or after ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  assign ptr_nxt   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  assign req_ready = gnt ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = gnt_any ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      wcnt       <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTROB     <= '0;
      PPROT      <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      PSEL    <= (state_nxt != IDLE);
      PENABLE <= (state_nxt == ACCESS);
      if (gnt) begin
        owner  <= gnt_idx;
        ptr    <= ptr_nxt;
        PADDR  <= reqs[gnt_idx].addr;
        PWDATA <= reqs[gnt_idx].wdata;
        PWRITE <= reqs[gnt_idx].write;
        PSTROB <= reqs[gnt_idx].strob;
        PPROT  <= reqs[gnt_idx].prot;
      end
      if (state == SETUP)
        wcnt <= '0;
      else if (state == ACCESS && !PREADY && wcnt != CNT_MAX)
        wcnt <= wcnt + 1'b1;
      resp_valid <= done ? (NUM_REQ'(1) << owner) : '0;
      resp_err   <= done && (PREADY ? PSLVERR : 1'b1);
      resp_rdata <= (done && PREADY && !PWRITE) ? PRDATA : '0;
    end
  end
endmodule

// File: tb/tb_apb_mas_arb_ctrl.sv
// Directed bench: expected responses queued at grant, checked by an independent monitor.
module tb_apb_mas_arb_ctrl;
  localparam int N = 4, AW = 32, DW = 32, SW = 4, TO = 16;

  logic            clk = 0, rst = 1;
  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_strob = '0;
  logic [N*3-1:0]  req_prot = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic [DW-1:0]   resp_rdata, PWDATA, PRDATA;
  logic            resp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0]   PADDR;
  logic [SW-1:0]   PSTROB;
  logic [2:0]      PPROT;

  apb_mas_arb_ctrl #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
                     .APB_STROB_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_strob(req_strob),
    .req_prot(req_prot), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTROB(PSTROB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA));

  always #5 clk = ~clk;

  // Slave model: PREADY after ws wait cycles, never when hang is set.
  int   ws = 0;
  bit   hang = 0, slverr = 0;
  logic [DW-1:0] rd_val = '0;
  int   acc_cnt = 0;
  always @(posedge clk) acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
  assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= ws);
  assign PSLVERR = slverr;
  assign PRDATA  = rd_val;

  typedef struct {int idx; logic [DW-1:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  int   gnt_log[$];
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response and logs grants.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (|req_ready)
        for (int k = 0; k < N; k++) if (req_ready[k]) gnt_log.push_back(k);
      if (|resp_valid) begin
        if (sb.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_owner", 64'(resp_valid), 64'(N'(1) << e.idx));
          chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          chk("resp_err", 64'(resp_err), 64'(e.err));
        end
      end
    end
  end

  // Caller starts just after a rising edge; returns just after the capturing edge.
  task automatic send(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic wr, input logic [SW-1:0] s, input logic [2:0] p,
                      input logic [DW-1:0] er, input logic ee);
    int n;
    exp_t e;
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_write[i]          = wr;
    req_strob[i*SW +: SW] = s;
    req_prot[i*3 +: 3]    = p;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[i] && n < 200);
    if (!req_ready[i]) begin
      total++; bad++;
      $display("FAIL grant_wait: req%0d never granted", i);
    end else begin
      e.idx = i; e.rdata = er; e.err = ee;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic count_access(input int i, output int n);
    int b = 0;
    n = 0;
    while (b < 100) begin
      @(negedge clk); b++;
      if (resp_valid[i]) break;
      if (PSEL && PENABLE) n++;
    end
  endtask

  initial begin
    int n, low;
    // reset state
    @(negedge clk);
    chk("rst_psel", 64'(PSEL), 0);
    chk("rst_penable", 64'(PENABLE), 0);
    chk("rst_paddr", 64'(PADDR), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    @(negedge clk); rst = 0;

    // single write, zero wait states: exact phase timing
    @(posedge clk); #1;
    req_valid[0] = 1; req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'hA5A5_0001;
    req_write[0] = 1; req_strob[3:0] = 4'hF; req_prot[2:0] = 3'd2;
    @(negedge clk);
    chk("t1_grant", 64'(req_ready), 64'b0001);
    sb.push_back('{0, 32'h0, 1'b0});
    @(posedge clk); #1; req_valid[0] = 0;
    @(negedge clk);
    chk("t1_setup_psel", 64'(PSEL), 1);
    chk("t1_setup_pen", 64'(PENABLE), 0);
    chk("t1_paddr", 64'(PADDR), 64'h10);
    chk("t1_pwdata", 64'(PWDATA), 64'hA5A5_0001);
    chk("t1_pstrob_prot", 64'({PWRITE, PSTROB, PPROT}), 64'({1'b1, 4'hF, 3'd2}));
    @(negedge clk);
    chk("t1_access", 64'({PSEL, PENABLE}), 64'b11);
    @(negedge clk);
    chk("t1_resp_t3", 64'(resp_valid), 64'b0001);
    chk("t1_idle", 64'(PSEL), 0);
    drain();

    // read, 3 wait states
    ws = 3; rd_val = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    send(2, 32'h40, 32'h0, 1'b0, 4'h0, 3'd0, 32'hDEAD_BEEF, 1'b0);
    count_access(2, n);
    chk("t2_access_len", 64'(n), 4);
    chk("t2_paddr_hold", 64'(PADDR), 64'h40);
    drain();

    // slave error on write
    ws = 0; slverr = 1;
    @(posedge clk); #1;
    send(3, 32'h80, 32'h1234, 1'b1, 4'h3, 3'd1, 32'h0, 1'b1);
    drain();
    slverr = 0;

    // all requesters contending: order 0,1,2,3,0, PSEL never drops
    rd_val = 32'h1234_5678;
    gnt_log.delete();
    low = 0;
    @(posedge clk); #1;
    fork
      begin
        send(0, 32'h100, 32'hA0, 1'b1, 4'hF, 3'd0, 32'h0, 1'b0);
        send(0, 32'h104, 32'hA4, 1'b1, 4'hF, 3'd0, 32'h0, 1'b0);
      end
      send(1, 32'h110, 32'hB0, 1'b1, 4'hF, 3'd0, 32'h0, 1'b0);
      send(2, 32'h120, 32'h0,  1'b0, 4'h0, 3'd0, 32'h1234_5678, 1'b0);
      send(3, 32'h130, 32'hD0, 1'b1, 4'hF, 3'd0, 32'h0, 1'b0);
      begin
        int b = 0;
        @(negedge clk);
        while (!PSEL && b < 20) begin @(negedge clk); b++; end
        for (int c = 0; c < 10; c++) begin
          if (!PSEL) low++;
          @(negedge clk);
        end
      end
    join
    drain();
    chk("t4_psel_drops", 64'(low), 0);
    chk("t4_gnt_count", 64'(gnt_log.size()), 5);
    begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5 && k < gnt_log.size(); k++)
        chk($sformatf("t4_gnt_order%0d", k), 64'(gnt_log[k]), 64'(exp_order[k]));
    end

    // timeout: 16 stalled ACCESS cycles then abort to IDLE
    hang = 1;
    @(posedge clk); #1;
    send(1, 32'h200, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1);
    count_access(1, n);
    chk("t5_access_len", 64'(n), 16);
    chk("t5_idle", 64'({PSEL, PENABLE}), 0);
    drain();

    // async reset mid-ACCESS: outputs clear, no response, ptr back to 0
    @(posedge clk); #1;
    send(2, 32'h300, 32'h55, 1'b1, 4'hF, 3'd7, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_in_access", 64'({PSEL, PENABLE}), 64'b11);
    #2 rst = 1;
    #1;
    chk("t6_rst_psel_pen", 64'({PSEL, PENABLE, PWRITE}), 0);
    chk("t6_rst_paddr", 64'(PADDR), 0);
    chk("t6_rst_pwdata", 64'(PWDATA), 0);
    chk("t6_rst_pprot", 64'(PPROT), 0);
    sb.delete();
    @(negedge clk); rst = 0; hang = 0;
    gnt_log.delete();
    @(posedge clk); #1;
    fork
      send(3, 32'h330, 32'h33, 1'b1, 4'hF, 3'd0, 32'h0, 1'b0);
      send(0, 32'h300, 32'h30, 1'b1, 4'hF, 3'd0, 32'h0, 1'b0);
    join
    drain();
    chk("t6_gnt_count", 64'(gnt_log.size()), 2);
    if (gnt_log.size() == 2) begin
      chk("t6_first_gnt", 64'(gnt_log[0]), 0);
      chk("t6_second_gnt", 64'(gnt_log[1]), 3);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
